ntt_masked_share_splitter: RTL and testbench

// - Masking front end for the forward masked NTT/PWM datapath.
// - Takes unmasked coefficient/twiddle beats (two butterflies: u,v,w x2).
// - Splits each operand into two arithmetic shares mod 2^WIDTH using fresh randomness.
// - Emits a masked_bf_uvwi_t beat for the masked butterfly pair, under a valid/ready elastic pipeline.
// - Counts beats per polynomial and flags last beat and out-of-range inputs.

---
 rtl/ntt_masked_share_splitter_pkg.sv | 34 +++
 rtl/ntt_masked_share_splitter_if.sv | 27 ++
 rtl/ntt_masked_share_splitter_share_split.sv | 15 +
 rtl/ntt_masked_share_splitter.sv | 124 ++++++++++++
 tb/tb_ntt_masked_share_splitter.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ntt_masked_share_splitter_pkg.sv
// Shared types and constants for the masked NTT front end: unmasked input bundle,
// masked butterfly beat and per-operand mask words.
package ntt_masked_share_splitter_pkg;

  localparam int unsigned WIDTH              = 46;
  localparam int unsigned HALF_WIDTH         = WIDTH / 2;
  localparam int unsigned NUM_OPERANDS       = 6;
  localparam int unsigned NTT_BEATS_PER_POLY = 64;
  localparam int unsigned MLDSA_Q            = 8380417;

  // [0] = x - r, [1] = r
  typedef logic [1:0][WIDTH-1:0] masked_pair_t;

  typedef struct packed {
    masked_pair_t w01_i;
    masked_pair_t v01_i;
    masked_pair_t u01_i;
    masked_pair_t w00_i;
    masked_pair_t v00_i;
    masked_pair_t u00_i;
  } masked_bf_uvwi_t;

  typedef struct packed {
    logic [HALF_WIDTH-1:0] w01;
    logic [HALF_WIDTH-1:0] v01;
    logic [HALF_WIDTH-1:0] u01;
    logic [HALF_WIDTH-1:0] w00;
    logic [HALF_WIDTH-1:0] v00;
    logic [HALF_WIDTH-1:0] u00;
  } ntt_unmasked_uvw_t;

  typedef logic [NUM_OPERANDS-1:0][WIDTH-1:0] ntt_mask_words_t;

endpackage

// File: rtl/ntt_masked_share_splitter_if.sv
// Beat interface of the masking front end: unmasked beats and randomness in,
// masked butterfly beats out.
interface ntt_masked_share_splitter_if;
  import ntt_masked_share_splitter_pkg::*;

  logic              in_valid_i;
  logic              in_ready_o;
  ntt_unmasked_uvw_t in_data_i;
  logic              rnd_valid_i;
  ntt_mask_words_t   rnd_i;
  logic              out_valid_o;
  logic              out_ready_i;
  masked_bf_uvwi_t   uvw_o;
  logic              out_last_o;
  logic              range_err_o;

  modport slave (
    input  in_valid_i, in_data_i, rnd_valid_i, rnd_i, out_ready_i,
    output in_ready_o, out_valid_o, uvw_o, out_last_o, range_err_o
  );

  modport master (
    output in_valid_i, in_data_i, rnd_valid_i, rnd_i, out_ready_i,
    input  in_ready_o, out_valid_o, uvw_o, out_last_o, range_err_o
  );

endinterface

// File: rtl/ntt_masked_share_splitter_share_split.sv
// Arithmetic masking of one operand: x -> {x - r, r} modulo 2^WIDTH.
module ntt_share_split
  import ntt_masked_share_splitter_pkg::*;
(
  input  logic [HALF_WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0]      r_i,
  output logic [1:0][WIDTH-1:0] shares_o
);

  always_comb begin
    shares_o[0] = {{(WIDTH-HALF_WIDTH){1'b0}}, x_i} - r_i;
    shares_o[1] = r_i;
  end

endmodule

// File: rtl/ntt_masked_share_splitter.sv
// Masking front end: captures unmasked beats with fresh randomness (stage A), emits
// masked butterfly beats from an output register (stage B), counts beats per polynomial.
module ntt_masked_share_splitter
  import ntt_masked_share_splitter_pkg::*;
#(
  parameter int unsigned NUM_BEATS = NTT_BEATS_PER_POLY,
  parameter int unsigned PRIME     = MLDSA_Q
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        zeroize,
  ntt_masked_share_splitter_if.slave  bus
);

  localparam int unsigned      CNT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BEATS - 1);

  logic              a_valid_d, a_valid_q;
  ntt_unmasked_uvw_t a_x_d, a_x_q;
  ntt_mask_words_t   a_r_d, a_r_q;
  logic              out_valid_d, out_valid_q;
  masked_bf_uvwi_t   uvw_d, uvw_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              range_err_d, range_err_q;

  logic a_adv;
  logic in_ready;
  logic acc;
  logic out_hs;
  logic in_oor;

  logic [NUM_OPERANDS-1:0][HALF_WIDTH-1:0] a_x_ops;
  logic [NUM_OPERANDS-1:0][HALF_WIDTH-1:0] in_ops;
  logic [NUM_OPERANDS-1:0][1:0][WIDTH-1:0] a_shares;

  // Packed struct layout matches operand index order (u00 at index 0).
  assign a_x_ops = a_x_q;
  assign in_ops  = bus.in_data_i;

  for (genvar g = 0; g < NUM_OPERANDS; g++) begin : g_split
    ntt_share_split u_split (
      .x_i      (a_x_ops[g]),
      .r_i      (a_r_q[g]),
      .shares_o (a_shares[g])
    );
  end

  always_comb begin
    a_adv    = a_valid_q & (~out_valid_q | bus.out_ready_i) & ~zeroize;
    in_ready = ~zeroize & (~a_valid_q | a_adv);
    acc      = bus.in_valid_i & bus.rnd_valid_i & in_ready;
    out_hs   = out_valid_q & bus.out_ready_i & ~zeroize;
  end

  always_comb begin
    in_oor = 1'b0;
    for (int unsigned i = 0; i < NUM_OPERANDS; i++) begin
      if (32'(in_ops[i]) >= PRIME) in_oor = 1'b1;
    end
  end

  always_comb begin
    a_x_d       = a_x_q;
    a_r_d       = a_r_q;
    out_valid_d = out_valid_q;
    uvw_d       = uvw_q;
    cnt_d       = cnt_q;
    range_err_d = range_err_q;

    if (acc) begin
      a_x_d = bus.in_data_i;
      a_r_d = bus.rnd_i;
    end
    a_valid_d = acc | (a_valid_q & ~a_adv);

    // Stage B reloads whenever A advances, so drain and refill can share a cycle.
    if (a_adv) begin
      out_valid_d = 1'b1;
      uvw_d       = masked_bf_uvwi_t'(a_shares);
    end else if (bus.out_ready_i) begin
      out_valid_d = 1'b0;
    end

    if (out_hs) cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    if (acc && in_oor) range_err_d = 1'b1;

    if (zeroize) begin
      a_valid_d   = 1'b0;
      a_x_d       = '0;
      a_r_d       = '0;
      out_valid_d = 1'b0;
      uvw_d       = '0;
      cnt_d       = '0;
      range_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_valid_q   <= 1'b0;
      a_x_q       <= '0;
      a_r_q       <= '0;
      out_valid_q <= 1'b0;
      uvw_q       <= '0;
      cnt_q       <= '0;
      range_err_q <= 1'b0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_x_q       <= a_x_d;
      a_r_q       <= a_r_d;
      out_valid_q <= out_valid_d;
      uvw_q       <= uvw_d;
      cnt_q       <= cnt_d;
      range_err_q <= range_err_d;
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid_q;
  assign bus.uvw_o       = uvw_q;
  assign bus.out_last_o  = out_valid_q & (cnt_q == LAST_CNT);
  assign bus.range_err_o = range_err_q;

endmodule

// File: tb/tb_ntt_masked_share_splitter.sv
// Directed bench for the masking front end with a beat scoreboard that checks
// share reconstruction, mask pass-through, ordering and last-beat flags.
`timescale 1ns/1ps
module tb_ntt_masked_share_splitter;
  import ntt_masked_share_splitter_pkg::*;

  localparam int unsigned NUM_BEATS = NTT_BEATS_PER_POLY;
  localparam logic [HALF_WIDTH-1:0] Q = HALF_WIDTH'(MLDSA_Q);

  typedef logic [NUM_OPERANDS-1:0][1:0][WIDTH-1:0]      shares_arr_t;
  typedef logic [NUM_OPERANDS-1:0][HALF_WIDTH-1:0]      ops_arr_t;
  typedef struct packed { ntt_unmasked_uvw_t x; ntt_mask_words_t r; } beat_t;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic zeroize = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned hs_cnt   = 0;
  beat_t       exp_q[$];

  ntt_unmasked_uvw_t x;
  ntt_mask_words_t   r;
  shares_arr_t       sh;

  ntt_masked_share_splitter_if bus();

  ntt_masked_share_splitter #(
    .NUM_BEATS (NUM_BEATS),
    .PRIME     (MLDSA_Q)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .zeroize (zeroize),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ntt_unmasked_uvw_t mk_x(input int unsigned seed);
    ops_arr_t ops;
    for (int unsigned k = 0; k < NUM_OPERANDS; k++)
      ops[k] = HALF_WIDTH'((seed * 7919 + k * 104729) % MLDSA_Q);
    return ntt_unmasked_uvw_t'(ops);
  endfunction

  function automatic ntt_mask_words_t mk_r();
    ntt_mask_words_t rr;
    for (int unsigned k = 0; k < NUM_OPERANDS; k++)
      rr[k] = WIDTH'({$urandom(), $urandom()});
    return rr;
  endfunction

  task automatic drive(input logic v, input logic rv, input ntt_unmasked_uvw_t dx,
                       input ntt_mask_words_t dr, input logic ordy);
    bus.in_valid_i  = v;
    bus.rnd_valid_i = rv;
    bus.in_data_i   = dx;
    bus.rnd_i       = dr;
    bus.out_ready_i = ordy;
  endtask

  task automatic check_beat(input beat_t b);
    shares_arr_t    s;
    ops_arr_t       xs;
    logic [WIDTH-1:0] sum;
    s  = shares_arr_t'(bus.uvw_o);
    xs = ops_arr_t'(b.x);
    for (int unsigned k = 0; k < NUM_OPERANDS; k++) begin
      sum = s[k][0] + s[k][1];
      check("share1_is_r", 64'(s[k][1]), 64'(b.r[k]));
      check("reconstruct", 64'(sum), 64'(xs[k]));
    end
  endtask

  // One clock: score the output handshake and record the accepted beat, then advance.
  task automatic tick();
    logic  acc;
    logic  hs;
    beat_t b;
    #1;
    acc = bus.in_valid_i & bus.rnd_valid_i & bus.in_ready_o;
    hs  = bus.out_valid_o & bus.out_ready_i;
    if (hs) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 64'(hs), 64'd0);
      end else begin
        b = exp_q.pop_front();
        check_beat(b);
        check("out_last", 64'(bus.out_last_o), 64'((hs_cnt % NUM_BEATS) == NUM_BEATS - 1));
        hs_cnt++;
      end
    end
    if (acc) begin
      b.x = bus.in_data_i;
      b.r = bus.rnd_i;
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    for (int unsigned i = 0; i < 8 && (exp_q.size() != 0 || bus.out_valid_o); i++) tick();
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    check("drain_valid", 64'(bus.out_valid_o), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_out_last",  64'(bus.out_last_o),  64'd0);
    check("rst_range_err", 64'(bus.range_err_o), 64'd0);
    check("rst_uvw",       64'(|bus.uvw_o),      64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 64'(bus.in_ready_o), 64'd1);

    // Single beat: u00 = 1 masked with r = 5
    x = '0; x.u00 = HALF_WIDTH'(1);
    r = '0; r[0] = WIDTH'(5);
    drive(1'b1, 1'b1, x, r, 1'b1); #1;
    check("sb_in_ready", 64'(bus.in_ready_o), 64'd1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, '0, '0, 1'b1); #1;
    check("sb_n1_valid", 64'(bus.out_valid_o), 64'd0);
    @(posedge clk); #1;
    check("sb_n2_valid", 64'(bus.out_valid_o), 64'd1);
    sh = shares_arr_t'(bus.uvw_o);
    check("sb_u00_share0", 64'(sh[0][0]), 64'h3FFF_FFFF_FFFC);
    check("sb_u00_share1", 64'(sh[0][1]), 64'h5);
    check("sb_u00_sum23",  64'(HALF_WIDTH'(sh[0][0] + sh[0][1])), 64'd1);
    check("sb_v00_share0", 64'(sh[1][0]), 64'd0);
    check("sb_last",       64'(bus.out_last_o), 64'd0);
    @(posedge clk); #1;
    check("sb_done", 64'(bus.out_valid_o), 64'd0);
    hs_cnt = 1;

    // Range check around PRIME
    check("rng_init", 64'(bus.range_err_o), 64'd0);
    x = mk_x(1); x.u00 = Q - HALF_WIDTH'(1);
    drive(1'b1, 1'b1, x, mk_r(), 1'b1); tick();
    check("rng_below_q", 64'(bus.range_err_o), 64'd0);
    x = mk_x(2); x.v01 = Q;
    drive(1'b1, 1'b1, x, mk_r(), 1'b1); tick();
    check("rng_at_q", 64'(bus.range_err_o), 64'd1);
    drive(1'b1, 1'b1, mk_x(3), mk_r(), 1'b1); tick();
    drain();
    check("rng_sticky", 64'(bus.range_err_o), 64'd1);

    // Zeroize with both stages full
    drive(1'b1, 1'b1, mk_x(10), mk_r(), 1'b0); tick();
    drive(1'b1, 1'b1, mk_x(11), mk_r(), 1'b0); tick();
    check("zz_full_in_ready", 64'(bus.in_ready_o),  64'd0);
    check("zz_full_valid",    64'(bus.out_valid_o), 64'd1);
    zeroize = 1'b1; bus.out_ready_i = 1'b1; #1;
    check("zz_in_ready", 64'(bus.in_ready_o), 64'd0);
    @(posedge clk); #1;
    zeroize = 1'b0;
    drive(1'b0, 1'b0, '0, '0, 1'b1); #1;
    check("zz_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("zz_uvw",       64'(|bus.uvw_o),      64'd0);
    check("zz_out_last",  64'(bus.out_last_o),  64'd0);
    check("zz_range_err", 64'(bus.range_err_o), 64'd0);
    exp_q.delete();
    hs_cnt = 0;
    @(posedge clk); #1;
    check("zz_a_discarded", 64'(bus.out_valid_o), 64'd0);

    // Full-rate stream past one polynomial: last only on beat 64
    for (int unsigned i = 0; i < NUM_BEATS + 2; i++) begin
      drive(1'b1, 1'b1, mk_x(100 + i), mk_r(), 1'b1); #1;
      check("st_in_ready", 64'(bus.in_ready_o), 64'd1);
      if (i >= 2) check("st_out_valid", 64'(bus.out_valid_o), 64'd1);
      tick();
    end
    drain();
    check("st_beats", 64'(hs_cnt), 64'(NUM_BEATS + 2));

    // Randomness stall: held beat must not be taken until rnd_valid_i rises
    x = mk_x(300);
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, x, mk_r(), 1'b1);
      tick();
    end
    check("stall_no_out", 64'(bus.out_valid_o), 64'd0);
    check("stall_no_acc", 64'(exp_q.size()),    64'd0);
    drive(1'b1, 1'b1, mk_x(301), mk_r(), 1'b1); tick();
    drain();

    // Output backpressure on a full pipe
    for (int unsigned i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, mk_x(400 + i), mk_r(), 1'b1); tick();
    end
    x = mk_x(403); r = mk_r();
    for (int unsigned i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, x, r, 1'b0); #1;
      check("bp_in_ready",  64'(bus.in_ready_o),  64'd0);
      check("bp_out_valid", 64'(bus.out_valid_o), 64'd1);
      check_beat(exp_q[0]);
      tick();
    end
    drive(1'b1, 1'b1, x, r, 1'b1); tick();
    drain();

    // Asynchronous reset mid-stream
    x = mk_x(500); x.w00 = Q + HALF_WIDTH'(5);
    drive(1'b1, 1'b1, x, mk_r(), 1'b1); tick();
    drive(1'b1, 1'b1, mk_x(501), mk_r(), 1'b1); tick();
    check("ar_pre_range_err", 64'(bus.range_err_o), 64'd1);
    check("ar_pre_valid",     64'(bus.out_valid_o), 64'd1);
    #3; reset_n = 1'b0; #1;
    check("ar_out_valid", 64'(bus.out_valid_o), 64'd0);
    check("ar_uvw",       64'(|bus.uvw_o),      64'd0);
    check("ar_out_last",  64'(bus.out_last_o),  64'd0);
    check("ar_range_err", 64'(bus.range_err_o), 64'd0);
    exp_q.delete();
    hs_cnt = 0;
    drive(1'b0, 1'b0, '0, '0, 1'b1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("ar_in_ready",   64'(bus.in_ready_o),  64'd1);
    check("ar_post_valid", 64'(bus.out_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
